control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 171 +++++++++++++++++
 tb/tb_control_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multicycle control FSM: Moore decode of the state register, plus BRANCH PCWrite from alu_zero/funct3.
// Optional feature: define CTRL_BNE_EN to make bne (branch funct3 001) a legal instruction.
module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        alu_zero,
    output logic        PCWrite,
    output logic [1:0]  PCSource,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        LoadAOut,
    output logic        LoadRegA,
    output logic        LoadRegB,
    output logic        LoadMDR,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        DMemRead,
    output logic        DMemWrite,
    output logic        IMemRead,
    output logic [3:0]  state_out,
    output logic        halted
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_HALT      = 4'd9
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_e state_q, state_d;
    logic   resetHold_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       memLegal, rLegal, brLegal, branchTaken;
    logic       unusedBits;

    assign opcode     = instruction[6:0];
    assign funct3     = instruction[14:12];
    assign funct7     = instruction[31:25];
    assign unusedBits = ^{instruction[24:15], instruction[11:7]};

    assign memLegal = (funct3 == 3'b011);
    assign rLegal   = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
`ifdef CTRL_BNE_EN
    assign brLegal     = (funct3 == 3'b000) || (funct3 == 3'b001);
    assign branchTaken = ((funct3 == 3'b000) && alu_zero) || ((funct3 == 3'b001) && !alu_zero);
`else
    assign brLegal     = (funct3 == 3'b000);
    assign branchTaken = (funct3 == 3'b000) && alu_zero;
`endif

    // resetHold_q keeps outputs at zero for the cycle after reset is sampled low
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            resetHold_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            resetHold_q <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = memLegal ? S_MEM_ADDR : S_HALT;
                    OP_RTYPE:          state_d = rLegal   ? S_R_EXEC   : S_HALT;
                    OP_BRANCH:         state_d = brLegal  ? S_BRANCH   : S_HALT;
                    default:           state_d = S_HALT;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = S_MEM_WB;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = S_FETCH;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_HALT;
        endcase
        if (resetHold_q) begin
            state_d = S_FETCH;
        end
    end

    always_comb begin
        PCWrite   = 1'b0;
        PCSource  = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        LoadAOut  = 1'b0;
        LoadRegA  = 1'b0;
        LoadRegB  = 1'b0;
        LoadMDR   = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemToReg  = 1'b0;
        DMemRead  = 1'b0;
        DMemWrite = 1'b0;
        IMemRead  = 1'b0;
        halted    = 1'b0;
        state_out = state_q;
        if (!resetHold_q) begin
            case (state_q)
                S_FETCH: begin
                    IMemRead = 1'b1;
                    IRWrite  = 1'b1;
                    ALUSrcB  = 2'b01;
                    PCWrite  = 1'b1;
                end
                S_DECODE: begin
                    LoadRegA = 1'b1;
                    LoadRegB = 1'b1;
                    ALUSrcB  = 2'b11;
                    LoadAOut = 1'b1;
                end
                S_MEM_ADDR: begin
                    ALUSrcA  = 1'b1;
                    ALUSrcB  = 2'b10;
                    LoadAOut = 1'b1;
                end
                S_MEM_READ: begin
                    DMemRead = 1'b1;
                    LoadMDR  = 1'b1;
                end
                S_MEM_WB: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                S_MEM_WRITE: DMemWrite = 1'b1;
                S_R_EXEC: begin
                    ALUSrcA  = 1'b1;
                    ALUOp    = 2'b10;
                    LoadAOut = 1'b1;
                end
                S_R_WB: RegWrite = 1'b1;
                S_BRANCH: begin
                    ALUSrcA  = 1'b1;
                    ALUOp    = 2'b01;
                    PCSource = 2'b01;
                    PCWrite  = branchTaken;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit: per-cycle state and control-vector checks against hand-derived tables.
// Honours CTRL_BNE_EN the same way as the design.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instruction = 32'h00000033;
    logic        alu_zero = 1'b0;
    logic        PCWrite, ALUSrcA, LoadAOut, LoadRegA, LoadRegB, LoadMDR, IRWrite;
    logic        RegWrite, MemToReg, DMemRead, DMemWrite, IMemRead, halted;
    logic [1:0]  PCSource, ALUSrcB, ALUOp;
    logic [3:0]  state_out;
    logic [18:0] ctl;

    int checks = 0;
    int errors = 0;

    // Control word layout: PCWrite,PCSource,ALUSrcA,ALUSrcB,ALUOp,LoadAOut,LoadRegA,LoadRegB,LoadMDR,IRWrite,RegWrite,MemToReg,DMemRead,DMemWrite,IMemRead,halted
    localparam logic [18:0] C_ZERO   = 19'b0_00_0_00_00_0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [18:0] C_FETCH  = 19'b1_00_0_01_00_0_0_0_0_1_0_0_0_0_1_0;
    localparam logic [18:0] C_DECODE = 19'b0_00_0_11_00_1_1_1_0_0_0_0_0_0_0_0;
    localparam logic [18:0] C_MADDR  = 19'b0_00_1_10_00_1_0_0_0_0_0_0_0_0_0_0;
    localparam logic [18:0] C_MREAD  = 19'b0_00_0_00_00_0_0_0_1_0_0_0_1_0_0_0;
    localparam logic [18:0] C_MWB    = 19'b0_00_0_00_00_0_0_0_0_0_1_1_0_0_0_0;
    localparam logic [18:0] C_MWRITE = 19'b0_00_0_00_00_0_0_0_0_0_0_0_0_1_0_0;
    localparam logic [18:0] C_REXEC  = 19'b0_00_1_00_10_1_0_0_0_0_0_0_0_0_0_0;
    localparam logic [18:0] C_RWB    = 19'b0_00_0_00_00_0_0_0_0_0_1_0_0_0_0_0;
    localparam logic [18:0] C_BR_T   = 19'b1_01_1_00_01_0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [18:0] C_BR_N   = 19'b0_01_1_00_01_0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [18:0] C_HALT   = 19'b0_00_0_00_00_0_0_0_0_0_0_0_0_0_0_1;

    control_unit dut (
        .clk(clk), .reset(reset), .instruction(instruction), .alu_zero(alu_zero),
        .PCWrite(PCWrite), .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .LoadAOut(LoadAOut), .LoadRegA(LoadRegA), .LoadRegB(LoadRegB),
        .LoadMDR(LoadMDR), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .DMemRead(DMemRead), .DMemWrite(DMemWrite), .IMemRead(IMemRead),
        .state_out(state_out), .halted(halted)
    );

    assign ctl = {PCWrite, PCSource, ALUSrcA, ALUSrcB, ALUOp, LoadAOut, LoadRegA, LoadRegB,
                  LoadMDR, IRWrite, RegWrite, MemToReg, DMemRead, DMemWrite, IMemRead, halted};

    always #5 clk = ~clk;

    // Returns at the falling edge of the first FETCH cycle after reset is released
    task automatic startAfterReset(input logic [31:0] instr, input int lowCycles);
        @(negedge clk);
        reset       = 1'b0;
        instruction = instr;
        repeat (lowCycles) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (state_out !== 4'd0) begin
                errors++;
                $display("[TB] FAIL reset_state cyc%0d got %0d want 0", i, state_out);
            end
            checks++;
            if (ctl !== C_ZERO) begin
                errors++;
                $display("[TB] FAIL reset_ctl cyc%0d got %b want %b", i, ctl, C_ZERO);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== C_FETCH || state_out !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_first_fetch got %0d/%b want 0/%b", state_out, ctl, C_FETCH);
        end
    endtask

    task automatic test_rtype;
        logic [3:0]  expS [5];
        logic [18:0] expC [5];
        expS = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        expC = '{C_FETCH, C_DECODE, C_REXEC, C_RWB, C_FETCH};
        startAfterReset(32'h00000033, 2);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state_out !== expS[i]) begin
                errors++;
                $display("[TB] FAIL rtype_state cyc%0d got %0d want %0d", i + 1, state_out, expS[i]);
            end
            checks++;
            if (ctl !== expC[i]) begin
                errors++;
                $display("[TB] FAIL rtype_ctl cyc%0d got %b want %b", i + 1, ctl, expC[i]);
            end
            // garbage instruction after DECODE must not disturb R_EXEC/R_WB
            if (i == 2) instruction = 32'hFFFFFFFF;
            @(negedge clk);
        end
    endtask

    task automatic test_load;
        logic [3:0]  expS [6];
        logic [18:0] expC [6];
        expS = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        expC = '{C_FETCH, C_DECODE, C_MADDR, C_MREAD, C_MWB, C_FETCH};
        startAfterReset(32'h0080B283, 1);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (state_out !== expS[i]) begin
                errors++;
                $display("[TB] FAIL load_state cyc%0d got %0d want %0d", i + 1, state_out, expS[i]);
            end
            checks++;
            if (ctl !== expC[i]) begin
                errors++;
                $display("[TB] FAIL load_ctl cyc%0d got %b want %b", i + 1, ctl, expC[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_store;
        logic [3:0]  expS [5];
        logic [18:0] expC [5];
        expS = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        expC = '{C_FETCH, C_DECODE, C_MADDR, C_MWRITE, C_FETCH};
        startAfterReset(32'h0050B423, 1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state_out !== expS[i]) begin
                errors++;
                $display("[TB] FAIL store_state cyc%0d got %0d want %0d", i + 1, state_out, expS[i]);
            end
            checks++;
            if (ctl !== expC[i]) begin
                errors++;
                $display("[TB] FAIL store_ctl cyc%0d got %b want %b", i + 1, ctl, expC[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch_beq;
        logic [3:0]  expS [4];
        logic [18:0] expC [4];
        expS = '{4'd0, 4'd1, 4'd8, 4'd0};
        for (int z = 0; z < 2; z++) begin
            expC = '{C_FETCH, C_DECODE, (z == 1) ? C_BR_T : C_BR_N, C_FETCH};
            alu_zero = (z == 1);
            startAfterReset(32'h00000463, 1);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (state_out !== expS[i] || ctl !== expC[i]) begin
                    errors++;
                    $display("[TB] FAIL beq_z%0d cyc%0d got %0d/%b want %0d/%b",
                             z, i + 1, state_out, ctl, expS[i], expC[i]);
                end
                // PCWrite in BRANCH follows alu_zero combinationally
                if (i == 2) begin
                    alu_zero = (z == 0);
                    #1;
                    checks++;
                    if (PCWrite !== (z == 0)) begin
                        errors++;
                        $display("[TB] FAIL beq_comb_z%0d got %b want %b", z, PCWrite, (z == 0));
                    end
                    alu_zero = (z == 1);
                end
                @(negedge clk);
            end
        end
        alu_zero = 1'b0;
    endtask

    task automatic test_branch_bne;
        logic [3:0]  expS [4];
        logic [18:0] expC [4];
`ifdef CTRL_BNE_EN
        expS = '{4'd0, 4'd1, 4'd8, 4'd0};
        expC = '{C_FETCH, C_DECODE, C_BR_T, C_FETCH};
`else
        expS = '{4'd0, 4'd1, 4'd9, 4'd9};
        expC = '{C_FETCH, C_DECODE, C_HALT, C_HALT};
`endif
        alu_zero = 1'b0;
        startAfterReset(32'h00001463, 1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (state_out !== expS[i] || ctl !== expC[i]) begin
                errors++;
                $display("[TB] FAIL bne cyc%0d got %0d/%b want %0d/%b",
                         i + 1, state_out, ctl, expS[i], expC[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_halt;
        logic [3:0]  expS [8];
        logic [18:0] expC [8];
        expS = '{4'd0, 4'd1, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
        expC = '{C_FETCH, C_DECODE, C_HALT, C_HALT, C_HALT, C_HALT, C_HALT, C_HALT};
        startAfterReset(32'hFFFFFFFF, 1);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (state_out !== expS[i] || ctl !== expC[i]) begin
                errors++;
                $display("[TB] FAIL halt cyc%0d got %0d/%b want %0d/%b",
                         i + 1, state_out, ctl, expS[i], expC[i]);
            end
            if (i == 2) instruction = 32'h00000033;
            @(negedge clk);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (state_out !== 4'd0 || ctl !== C_ZERO) begin
            errors++;
            $display("[TB] FAIL halt_reset got %0d/%b want 0/%b", state_out, ctl, C_ZERO);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (state_out !== 4'd0 || ctl !== C_FETCH) begin
            errors++;
            $display("[TB] FAIL halt_refetch got %0d/%b want 0/%b", state_out, ctl, C_FETCH);
        end
        @(negedge clk);
        checks++;
        if (state_out !== 4'd1 || ctl !== C_DECODE) begin
            errors++;
            $display("[TB] FAIL halt_redecode got %0d/%b want 1/%b", state_out, ctl, C_DECODE);
        end
    endtask

    task automatic test_illegal;
        logic [31:0] instrs [6];
        logic [3:0]  expS3  [6];
        instrs = '{32'h0080A283, 32'h00000023, 32'h02000033, 32'h00004463, 32'h40000033, 32'h00000013};
        expS3  = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd6, 4'd9};
        for (int k = 0; k < 6; k++) begin
            startAfterReset(instrs[k], 1);
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (state_out !== expS3[k] || halted !== (expS3[k] == 4'd9)) begin
                errors++;
                $display("[TB] FAIL illegal_%0d instr %h got %0d/h%b want %0d",
                         k, instrs[k], state_out, halted, expS3[k]);
            end
        end
    endtask

    task automatic test_reset_mid;
        startAfterReset(32'h0080B283, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (state_out !== 4'd0 || ctl !== C_ZERO) begin
            errors++;
            $display("[TB] FAIL mid_reset got %0d/%b want 0/%b", state_out, ctl, C_ZERO);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (state_out !== 4'd0 || ctl !== C_FETCH) begin
            errors++;
            $display("[TB] FAIL mid_refetch got %0d/%b want 0/%b", state_out, ctl, C_FETCH);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  expS  [13];
        logic [31:0] newIr [13];
        expS  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd1, 4'd8, 4'd0};
        newIr = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0050B423, 32'h0, 32'h0, 32'h0,
                  32'h00000463, 32'h0, 32'h0, 32'h0};
        alu_zero = 1'b1;
        startAfterReset(32'h0080B283, 1);
        for (int i = 0; i < 13; i++) begin
            if (newIr[i] != 32'h0) instruction = newIr[i];
            checks++;
            if (state_out !== expS[i]) begin
                errors++;
                $display("[TB] FAIL b2b_state cyc%0d got %0d want %0d", i + 1, state_out, expS[i]);
            end
            @(negedge clk);
        end
        alu_zero = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        $display("[TB] control_unit bench start");
        test_reset();
        test_rtype();
        test_load();
        test_store();
        test_branch_beq();
        test_branch_bne();
        test_halt();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
